rtc_save_writer: RTL and testbench

//  Transmit side of the cartridge RTC backup footer. Snapshots the live MBC3 RTC
//  (timestamp + packed time/halt/overflow) and streams it as 16-bit words to the

---
 rtl/gb_rtc_pkg.sv | 48 ++++
 rtl/rtc_save_writer_if.sv | 14 +
 rtl/rtc_save_writer_stable.sv | 40 ++++
 rtl/rtc_save_writer.sv | 127 ++++++++++++
 tb/tb_rtc_save_writer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_rtc_pkg.sv
// Shared RTC backup-footer definitions.
// Used by this save writer and by the mapper's bk_rtc_wr load path, so both sides agree
// on the word indices and the savedtime field layout.
//   word 0 ts[15:0], 1 ts[31:16], 2 sv[15:0], 3 sv[31:16], 4 commit magic
package gb_rtc_pkg;

  localparam int RTC_FOOTER_WORDS = 5;

  localparam logic [7:0] RTC_W_TS_LO  = 8'd0;
  localparam logic [7:0] RTC_W_TS_HI  = 8'd1;
  localparam logic [7:0] RTC_W_SV_LO  = 8'd2;
  localparam logic [7:0] RTC_W_SV_HI  = 8'd3;
  localparam logic [7:0] RTC_W_COMMIT = 8'd4;

  // Bit offsets of the fields inside RTC_savedtime.
  localparam int RTC_SEC_OFS  = 0;
  localparam int RTC_MIN_OFS  = 6;
  localparam int RTC_HR_OFS   = 12;
  localparam int RTC_DAY_OFS  = 17;
  localparam int RTC_OVF_OFS  = 27;
  localparam int RTC_HALT_OFS = 28;

  // Live-time compare covers sec..halt; the bits above are padding.
  localparam int RTC_CMP_W = RTC_HALT_OFS + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } rtc_wr_state_e;

  function automatic logic [15:0] rtc_footer_word(input logic [7:0]  idx,
                                                  input logic [31:0] ts,
                                                  input logic [47:0] sv,
                                                  input logic [15:0] magic);
    logic [15:0] w;
    case (idx)
      RTC_W_TS_LO: w = ts[15:0];
      RTC_W_TS_HI: w = ts[31:16];
      RTC_W_SV_LO: w = sv[15:0];
      RTC_W_SV_HI: w = sv[31:16];
      default:     w = magic;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rtc_save_writer_if.sv
// Word channel from the RTC footer writer to the save controller.
//   bk_rtc_addr  word index 0..4
//   bk_rtc_dout  word data
//   bk_rtc_valid word presented (held with addr/dout until ack)
//   bk_rtc_ack   word accepted
interface rtc_save_writer_if;
  logic [7:0]  bk_rtc_addr;
  logic [15:0] bk_rtc_dout;
  logic        bk_rtc_valid;
  logic        bk_rtc_ack;

  modport master (output bk_rtc_addr, bk_rtc_dout, bk_rtc_valid, input bk_rtc_ack);
  modport slave  (input bk_rtc_addr, bk_rtc_dout, bk_rtc_valid, output bk_rtc_ack);
endinterface

// File: rtl/rtc_save_writer_stable.sv
// rtc_stable_detect: flags when a sample has held the same value long enough.
//   clk_sys, reset  clock / synchronous active-high reset
//   run             detection window; low discards history
//   sample          value being watched
//   stable          this cycle is the STABLE_CYCLES-th consecutive equal compare
// The first cycle of a window only loads the reference, so no compare is possible there.
module rtc_stable_detect import gb_rtc_pkg::*; #(
  parameter int W             = RTC_CMP_W,
  parameter int STABLE_CYCLES = 2
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         run,
  input  logic [W-1:0] sample,
  output logic         stable
);
  localparam int            CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CYCLES - 1);

  logic [W-1:0]  prev;
  logic          prev_vld;
  logic [CW-1:0] cnt;
  logic          eq;

  assign eq     = run && prev_vld && (sample == prev);
  assign stable = eq && (cnt == CNT_TOP);

  always_ff @(posedge clk_sys) begin
    if (reset || !run) begin
      prev     <= '0;
      prev_vld <= 1'b0;
      cnt      <= '0;
    end else begin
      prev     <= sample;
      prev_vld <= 1'b1;
      if (!eq)                 cnt <= '0;
      else if (cnt != CNT_TOP) cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/rtc_save_writer.sv
// rtc_save_writer: snapshots the live MBC3 RTC and streams the 5-word backup footer.
//   clk_sys, reset   clock / synchronous active-high reset
//   enable           RTC-capable mapper active; low forces IDLE and zero outputs
//   RTC_inuse        RTC is meaningful for this game/save
//   RTC_timestamp    live unix-seconds timestamp
//   RTC_savedtime    packed {19'b0,halt,ovf,days,hours,min,sec}
//   save_req         1-cycle start pulse (ignored while busy)
//   bk               word channel master (addr/dout/valid out, ack in)
//   busy             settle or send in progress
//   done             1-cycle end pulse, also for a skipped (RTC unused) request
//   dirty            live RTC differs from the last completed footer
module rtc_save_writer import gb_rtc_pkg::*; #(
  parameter int          STABLE_CYCLES = 2,
  parameter int          SETTLE_MAX    = 255,
  parameter logic [15:0] FOOTER_MAGIC  = 16'h5254
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                enable,
  input  logic                RTC_inuse,
  input  logic [31:0]         RTC_timestamp,
  input  logic [47:0]         RTC_savedtime,
  input  logic                save_req,
  rtc_save_writer_if.master   bk,
  output logic                busy,
  output logic                done,
  output logic                dirty
);
  localparam int            SW         = $clog2(SETTLE_MAX + 1);
  localparam logic [SW-1:0] SETTLE_TOP = SW'(SETTLE_MAX);

  rtc_wr_state_e          state, state_n;
  logic [2:0]             word_idx;
  logic [7:0]             addr_cur;
  logic [SW-1:0]          settle_cnt;
  logic [31:0]            snap_ts;
  logic [47:0]            snap_sv;
  logic [RTC_CMP_W-1:0]   last_sent;
  logic [RTC_CMP_W-1:0]   live_cmp, dirty_ref;
  logic                   dirty_q, skip_q;
  logic                   stable, capture, last_word;

  assign live_cmp  = RTC_savedtime[RTC_CMP_W-1:0];
  assign addr_cur  = {5'b0, word_idx};
  assign last_word = (word_idx == 3'(RTC_FOOTER_WORDS - 1));
  assign capture   = (state == ST_SETTLE) && (stable || settle_cnt == SETTLE_TOP);
  // In DONE the snapshot becomes the new reference, so a set/clear decision that cycle
  // must already compare against it rather than the outgoing last_sent.
  assign dirty_ref = (state == ST_DONE) ? snap_sv[RTC_CMP_W-1:0] : last_sent;
  assign dirty     = dirty_q;

  rtc_stable_detect #(.W(RTC_CMP_W), .STABLE_CYCLES(STABLE_CYCLES)) u_stable (
    .clk_sys (clk_sys),
    .reset   (reset),
    .run     (enable && state == ST_SETTLE),
    .sample  (live_cmp),
    .stable  (stable)
  );

  always_ff @(posedge clk_sys) begin
    if (reset || !enable) state <= ST_IDLE;
    else                  state <= state_n;
  end

  always_comb begin
    state_n         = state;
    bk.bk_rtc_valid = 1'b0;
    bk.bk_rtc_addr  = '0;
    bk.bk_rtc_dout  = '0;
    busy            = 1'b0;
    done            = enable && skip_q;
    case (state)
      ST_IDLE:   if (save_req && RTC_inuse) state_n = ST_SETTLE;
      ST_SETTLE: begin
        busy = enable;
        if (capture) state_n = ST_SEND;
      end
      ST_SEND: begin
        busy            = enable;
        bk.bk_rtc_valid = enable;
        if (enable) begin
          bk.bk_rtc_addr = addr_cur;
          bk.bk_rtc_dout = rtc_footer_word(addr_cur, snap_ts, snap_sv, FOOTER_MAGIC);
        end
        if (bk.bk_rtc_ack && last_word) state_n = ST_DONE;
      end
      ST_DONE: begin
        done    = enable;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset || !enable) begin
      word_idx   <= '0;
      settle_cnt <= '0;
      snap_ts    <= '0;
      snap_sv    <= '0;
      dirty_q    <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      skip_q <= (state == ST_IDLE) && save_req && !RTC_inuse;

      if (state != ST_SETTLE)          settle_cnt <= '0;
      else if (settle_cnt != SETTLE_TOP) settle_cnt <= settle_cnt + SW'(1);

      if (capture) begin
        snap_ts <= RTC_timestamp;
        snap_sv <= RTC_savedtime;
      end

      if (state != ST_SEND)                   word_idx <= '0;
      else if (bk.bk_rtc_ack && !last_word)   word_idx <= word_idx + 3'd1;

      // Set wins over clear.
      if (RTC_inuse && live_cmp != dirty_ref)                         dirty_q <= 1'b1;
      else if (state == ST_DONE && live_cmp == snap_sv[RTC_CMP_W-1:0]) dirty_q <= 1'b0;
    end
  end

  // Reference for dirty survives reset/enable drops; only a completed footer moves it.
  always_ff @(posedge clk_sys) begin
    if (!reset && enable && state == ST_DONE) last_sent <= snap_sv[RTC_CMP_W-1:0];
  end
endmodule

// File: tb/tb_rtc_save_writer.sv
// Directed bench for rtc_save_writer: footer words, ack stalls, forced settle,
// skipped request, reset and enable drop mid-transfer, RTC change during send.
module tb_rtc_save_writer;
  logic        clk_sys = 1'b0;
  logic        reset, enable, RTC_inuse, save_req;
  logic [31:0] RTC_timestamp;
  logic [47:0] RTC_savedtime;
  logic        busy, done, dirty;

  rtc_save_writer_if bus ();

  rtc_save_writer dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .enable        (enable),
    .RTC_inuse     (RTC_inuse),
    .RTC_timestamp (RTC_timestamp),
    .RTC_savedtime (RTC_savedtime),
    .save_req      (save_req),
    .bk            (bus),
    .busy          (busy),
    .done          (done),
    .dirty         (dirty)
  );

  always #5 clk_sys = ~clk_sys;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Monitor on the falling edge: valid&ack seen here is the transfer at the next rise.
  logic [15:0] words [8];
  logic [7:0]  waddr [8];
  int          nw, ndone, nbusy, stab_err;
  logic        mon_clr = 1'b0;
  logic        pv, pa;
  logic [7:0]  paddr;
  logic [15:0] pdout;

  always @(negedge clk_sys) begin
    if (mon_clr) begin
      nw <= 0; ndone <= 0; nbusy <= 0; stab_err <= 0; pv <= 1'b0; pa <= 1'b0;
    end else if (!reset) begin
      if (bus.bk_rtc_valid && bus.bk_rtc_ack) begin
        if (nw < 8) begin
          words[nw] <= bus.bk_rtc_dout;
          waddr[nw] <= bus.bk_rtc_addr;
        end
        nw <= nw + 1;
      end
      if (done) ndone <= ndone + 1;
      if (busy) nbusy <= nbusy + 1;
      if (pv && !pa && bus.bk_rtc_valid &&
          (bus.bk_rtc_addr != paddr || bus.bk_rtc_dout != pdout))
        stab_err <= stab_err + 1;
      pv    <= bus.bk_rtc_valid;
      pa    <= bus.bk_rtc_ack;
      paddr <= bus.bk_rtc_addr;
      pdout <= bus.bk_rtc_dout;
    end
  end

  task automatic mon_reset();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!bus.bk_rtc_valid && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_req();
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
  endtask

  localparam logic [47:0] SV_A = 48'h0000_1111_2222;
  localparam logic [47:0] SV_B = 48'h0000_0333_4444;

  initial begin
    int n, seen;
    logic [15:0] exp_w [5];

    reset = 1'b1; enable = 1'b1; RTC_inuse = 1'b0; save_req = 1'b0;
    RTC_timestamp = '0; RTC_savedtime = '0; bus.bk_rtc_ack = 1'b0;
    repeat (3) tick();
    chk("rst_valid", bus.bk_rtc_valid, 1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_dirty", dirty, 1'b0);
    chk("rst_addr",  bus.bk_rtc_addr, 8'h00);
    chk("rst_dout",  bus.bk_rtc_dout, 16'h0000);
    reset = 1'b0;
    mon_reset();

    // 1: stable RTC, ack always high -> 5 words in 5 cycles
    RTC_timestamp = 32'h6543_21AB; RTC_savedtime = 48'h0000_1234_5678;
    RTC_inuse = 1'b1; bus.bk_rtc_ack = 1'b1;
    tick();
    pulse_req();
    chk("t1_busy", busy, 1'b1);
    wait_valid(20, n);
    chk("t1_lat", n, 3);
    exp_w = '{16'h21AB, 16'h6543, 16'h5678, 16'h1234, 16'h5254};
    for (int w = 0; w < 5; w++) begin
      chk($sformatf("t1_addr%0d", w), bus.bk_rtc_addr, 8'(w));
      chk($sformatf("t1_dout%0d", w), bus.bk_rtc_dout, exp_w[w]);
      tick();
    end
    chk("t1_done",  done, 1'b1);
    chk("t1_busy0", busy, 1'b0);
    chk("t1_vld0",  bus.bk_rtc_valid, 1'b0);
    tick();
    chk("t1_done0", done, 1'b0);
    chk("t1_dirty", dirty, 1'b0);

    // 2: ack held low 10 cycles per word
    RTC_timestamp = 32'hDEAD_BEEF; RTC_savedtime = 48'h0000_0A1B_2C3D;
    bus.bk_rtc_ack = 1'b0;
    mon_reset();
    pulse_req();
    wait_valid(20, n);
    chk("t2_lat", n, 3);
    exp_w = '{16'hBEEF, 16'hDEAD, 16'h2C3D, 16'h0A1B, 16'h5254};
    for (int w = 0; w < 5; w++) begin
      repeat (10) tick();
      chk($sformatf("t2_hold%0d", w), {bus.bk_rtc_valid, bus.bk_rtc_addr}, {1'b1, 8'(w)});
      bus.bk_rtc_ack = 1'b1;
      tick();
      bus.bk_rtc_ack = 1'b0;
    end
    chk("t2_done", done, 1'b1);
    tick();
    chk("t2_nw",    nw, 5);
    chk("t2_ndone", ndone, 1);
    chk("t2_stab",  stab_err, 0);
    for (int w = 0; w < 5; w++) begin
      chk($sformatf("t2_w%0d", w), {waddr[w], words[w]}, {8'(w), exp_w[w]});
    end

    // 3: savedtime toggles every cycle -> snapshot forced after 256 settle cycles
    RTC_timestamp = 32'h0BAD_F00D;
    bus.bk_rtc_ack = 1'b1;
    mon_reset();
    RTC_savedtime = SV_A;
    pulse_req();
    seen = 0;
    for (int k = 1; k <= 300; k++) begin
      RTC_savedtime = k[0] ? SV_A : SV_B;
      tick();
      if (seen == 0 && bus.bk_rtc_valid) seen = k;
    end
    chk("t3_lat",   seen, 256);
    chk("t3_nw",    nw, 5);
    chk("t3_ndone", ndone, 1);
    chk("t3_ts",    {words[1], words[0]}, 32'h0BAD_F00D);
    chk("t3_sv",    {words[3], words[2]}, SV_B[31:0]);

    // 4: RTC not in use -> done next cycle, no words, never busy
    RTC_inuse = 1'b0;
    mon_reset();
    pulse_req();
    chk("t4_done",  done, 1'b1);
    chk("t4_busy",  busy, 1'b0);
    chk("t4_vld",   bus.bk_rtc_valid, 1'b0);
    tick();
    chk("t4_done0", done, 1'b0);
    repeat (5) tick();
    chk("t4_nw",    nw, 0);
    chk("t4_nbusy", nbusy, 0);
    chk("t4_ndone", ndone, 1);

    // 5: reset after word 2 accepted
    RTC_inuse = 1'b1; RTC_timestamp = 32'h1357_9BDF; RTC_savedtime = 48'h0000_0000_0777;
    mon_reset();
    pulse_req();
    wait_valid(20, n);
    chk("t5_lat",   n, 3);
    chk("t5_dirty", dirty, 1'b1);
    repeat (3) tick();
    chk("t5_addr3", bus.bk_rtc_addr, 8'h03);
    reset = 1'b1; bus.bk_rtc_ack = 1'b0;
    tick();
    chk("t5_vld",  bus.bk_rtc_valid, 1'b0);
    chk("t5_done", done, 1'b0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("t5_busy",   busy, 1'b0);
    chk("t5_dirty1", dirty, 1'b1);
    chk("t5_ndone",  ndone, 0);
    chk("t5_nw",     nw, 3);

    // 6: seconds tick during SEND; extra req while busy is dropped
    RTC_timestamp = 32'hCAFE_0001; RTC_savedtime = 48'h0000_0002_1000;
    bus.bk_rtc_ack = 1'b1;
    mon_reset();
    pulse_req();
    wait_valid(20, n);
    chk("t6_lat", n, 3);
    RTC_savedtime = 48'h0000_0002_1001;
    pulse_req();
    repeat (6) tick();
    chk("t6_nw",    nw, 5);
    chk("t6_ndone", ndone, 1);
    chk("t6_sv",    {words[3], words[2]}, 32'h0002_1000);
    chk("t6_ts",    {words[1], words[0]}, 32'hCAFE_0001);
    chk("t6_dirty", dirty, 1'b1);
    chk("t6_busy",  busy, 1'b0);

    // 7: enable drop mid-transfer zeroes outputs at once and aborts
    mon_reset();
    pulse_req();
    wait_valid(20, n);
    chk("t7_lat", n, 3);
    enable = 1'b0;
    #1;
    chk("t7_out", {bus.bk_rtc_valid, bus.bk_rtc_addr, bus.bk_rtc_dout, busy}, 26'h0);
    tick();
    enable = 1'b1;
    tick();
    chk("t7_idle",  {bus.bk_rtc_valid, busy}, 2'b00);
    chk("t7_ndone", ndone, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
